i2c_target: RTL and testbench

- I2C responder (slave) for the same bus the on-board I2C controller drives.
- Used as an FPGA-side test target and for inter-board links on the S1 Popout D5/D6 pins.
- Oversamples SCL/SDA on the system clock (6 MHz HFOSC) and detects START/STOP.
- Matches a 7-bit address, ACKs it, and then either accepts write bytes or serves read bytes through a byte-wide handshake.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_sync.sv | 65 ++++++
 rtl/i2c_target.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its line conditioner.
package i2c_pkg;

    // Protocol phases of the target. The encoding is never relied on outside this package.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } state_t;

    // R/W bit carried in the LSB of the address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Level on SDA during the ninth (acknowledge) clock
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Compare the upper seven bits of a received address byte against the target address
    function automatic logic addr_match(input logic [6:0] received, input logic [6:0] target);
        return received == target;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input conditioning: metastability chain, one history stage, and
// single-cycle strobes for SCL edges and START/STOP bus conditions.
// Shared between the target and the controller side of the bus.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic [SYNC_STAGES-1:0] scl_sync_next;
    logic [SYNC_STAGES-1:0] sda_sync_next;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;
    logic                   scl;

    // Each chain stage takes the previous one; stage 0 takes the raw pad.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign scl_sync_next[gi] = scl_in;
                assign sda_sync_next[gi] = sda_in;
            end else begin : g_rest
                assign scl_sync_next[gi] = scl_sync_reg[gi-1];
                assign sda_sync_next[gi] = sda_sync_reg[gi-1];
            end
        end
    endgenerate

    // Shift the synchronisers and keep last cycle's value. Reset to the idle
    // (high) bus level so leaving reset never produces a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= scl_sync_next;
            sda_sync_reg <= sda_sync_next;
            scl_hist_reg <= scl;
            sda_hist_reg <= sda;
        end
    end

    assign scl = scl_sync_reg[SYNC_STAGES-1];
    assign sda = sda_sync_reg[SYNC_STAGES-1];

    assign scl_rise  = scl & ~scl_hist_reg;
    assign scl_fall  = ~scl & scl_hist_reg;
    // SDA edges only count as bus conditions when SCL was high on both samples
    assign start_det = scl & scl_hist_reg & sda_hist_reg & ~sda;
    assign stop_det  = scl & scl_hist_reg & ~sda_hist_reg & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave): 7-bit address match, write bytes delivered on
// rx_data/rx_valid, read bytes fetched through the tx_req/tx_data handshake.
// SDA is only ever pulled low by sda_oe and only changed after SCL falls.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h4D,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       addressed,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       rw_reg;
    // A full byte has been shifted and the acknowledge phase starts on the next SCL fall
    logic       byte_done_reg;
    logic       sda_oe_reg;
    logic       addressed_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       tx_req_reg;
    logic       busy_reg;

    // Protocol FSM. Bus conditions pre-empt every state; within a state, data is
    // sampled on SCL rise and SDA drive only changes on SCL fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            rw_reg        <= RW_WRITE;
            byte_done_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
            addressed_reg <= 1'b0;
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;

            if (start_det) begin
                // START and repeated START look the same: fresh address phase
                state_reg     <= ADDR;
                busy_reg      <= 1'b1;
                bit_cnt_reg   <= 3'd0;
                byte_done_reg <= 1'b0;
                addressed_reg <= 1'b0;
                sda_oe_reg    <= 1'b0;
            end else if (stop_det) begin
                // Any partial byte is dropped silently
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                byte_done_reg <= 1'b0;
                addressed_reg <= 1'b0;
                sda_oe_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        sda_oe_reg <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda};
                            if (bit_cnt_reg == 3'd7) begin
                                // shift_reg[6:0] holds the seven address bits; sda is R/W
                                rw_reg <= sda;
                                if (addr_match(shift_reg[6:0], ADDRESS)) begin
                                    byte_done_reg <= 1'b1;
                                end else begin
                                    state_reg  <= IGNORE;
                                    sda_oe_reg <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            sda_oe_reg    <= 1'b1;
                            state_reg     <= ADDR_ACK;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_rise) begin
                            addressed_reg <= 1'b1;
                            if (rw_reg == RW_READ) begin
                                tx_req_reg <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            bit_cnt_reg <= 3'd0;
                            if (rw_reg == RW_WRITE) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= WRITE;
                            end else begin
                                shift_reg  <= tx_data;
                                sda_oe_reg <= ~tx_data[7];
                                state_reg  <= READ;
                            end
                        end
                    end

                    WRITE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda};
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data_reg   <= {shift_reg[6:0], sda};
                                rx_valid_reg  <= 1'b1;
                                byte_done_reg <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            sda_oe_reg    <= 1'b1;
                            state_reg     <= WRITE_ACK;
                        end
                    end

                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= 3'd0;
                            state_reg   <= WRITE;
                        end
                    end

                    READ: begin
                        // bit_cnt counts bits whose clock has already ended
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= READ_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                sda_oe_reg  <= ~shift_reg[6];
                            end
                        end
                    end

                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda == ACK) begin
                                tx_req_reg    <= 1'b1;
                                byte_done_reg <= 1'b1;
                            end else begin
                                state_reg <= IGNORE;
                            end
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            bit_cnt_reg   <= 3'd0;
                            shift_reg     <= tx_data;
                            sda_oe_reg    <= ~tx_data[7];
                            state_reg     <= READ;
                        end
                    end

                    IGNORE: begin
                        sda_oe_reg <= 1'b0;
                    end

                    default: begin
                        state_reg  <= IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign addressed = addressed_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign tx_req    = tx_req_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a timed bus controller drives SCL/SDA,
// a monitor scoreboards rx_valid bytes and serves tx_req from a queue.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] ADDRESS = 7'h4D;
    localparam int         Q       = 5;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in = 1'b1;
    logic       ctrl_sda_low = 1'b0;
    logic       sda_in;
    logic       sda_oe;
    logic       addressed;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    // Open-drain wired-AND bus with pull-up
    assign sda_in = ~(ctrl_sda_low | sda_oe);

    i2c_target #(
        .ADDRESS    (ADDRESS),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .addressed(addressed),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         tx_req_cnt = 0;
    int         oe_violations = 0;
    bit         allow_oe_glitch = 1'b1;
    logic       prev_oe = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] payload[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard received bytes, act as the application for tx_req,
    // and flag any SDA drive change while SCL is high.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_rx_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: actual rx_data=%02h required no rx_valid", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
        end
        if (tx_req) begin
            tx_req_cnt++;
            if (tx_src_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_req_unexpected: actual tx_req=1 required 0");
            end else begin
                tx_data = tx_src_q.pop_front();
            end
        end
        if (!allow_oe_glitch && sda_oe !== prev_oe && scl_in) oe_violations++;
        prev_oe = sda_oe;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl_in == 1'b0) begin
            ctrl_sda_low = 1'b0;
            clks(Q);
            scl_in = 1'b1;
            clks(Q);
        end
        ctrl_sda_low = 1'b1;
        clks(Q);
        scl_in = 1'b0;
        clks(Q);
    endtask

    task automatic bus_stop();
        ctrl_sda_low = 1'b1;
        clks(Q);
        scl_in = 1'b1;
        clks(Q);
        ctrl_sda_low = 1'b0;
        clks(Q);
    endtask

    task automatic write_bit(input logic b);
        ctrl_sda_low = ~b;
        clks(Q);
        scl_in = 1'b1;
        clks(2 * Q);
        scl_in = 1'b0;
        clks(Q);
    endtask

    task automatic read_bit(output logic b);
        ctrl_sda_low = 1'b0;
        clks(Q);
        scl_in = 1'b1;
        clks(Q);
        b = sda_in;
        clks(Q);
        scl_in = 1'b0;
        clks(Q);
    endtask

    // Eight data bits then the ninth clock; ack=1 when the target pulled SDA low
    task automatic write_byte(input logic [7:0] d, output bit ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = (b == 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] d, input bit send_ack);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(send_ack ? 1'b0 : 1'b1);
    endtask

    // One complete transaction using the bytes in payload. Expected behaviour:
    // ack and deliver only when the address matches; a read ACKs every byte
    // except the last and returns the payload bytes in order.
    task automatic xfer(input logic [7:0] addr_byte);
        bit         match;
        bit         is_read;
        bit         ack;
        logic [7:0] got;
        int         n;
        int         req0;
        n       = payload.size();
        match   = (addr_byte[7:1] == ADDRESS);
        is_read = addr_byte[0];
        $display("[TB] xfer addr=%02h bytes=%0d match=%0d read=%0d", addr_byte, n, match, is_read);
        if (match && is_read) begin
            for (int i = 0; i < n; i++) tx_src_q.push_back(payload[i]);
        end
        req0 = tx_req_cnt;
        bus_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        write_byte(addr_byte, ack);
        check("addr_ack", {31'd0, ack}, {31'd0, match});
        check("addressed", {31'd0, addressed}, {31'd0, match});
        if (match && is_read) begin
            for (int i = 0; i < n; i++) begin
                read_byte(got, i < n - 1);
                check("read_byte", {24'd0, got}, {24'd0, payload[i]});
            end
            check("sda_released_after_nack", {31'd0, sda_oe}, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (match) exp_rx_q.push_back(payload[i]);
                write_byte(payload[i], ack);
                check("data_ack", {31'd0, ack}, {31'd0, match});
            end
        end
        check("tx_req_count", tx_req_cnt - req0, (match && is_read) ? n : 0);
        bus_stop();
        clks(4);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("addressed_after_stop", {31'd0, addressed}, 32'd0);
        check("sda_oe_after_stop", {31'd0, sda_oe}, 32'd0);
        check("rx_pending", exp_rx_q.size(), 32'd0);
        check("tx_pending", tx_src_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sda_oe"}, {31'd0, sda_oe}, 32'd0);
        check({tag, "_addressed"}, {31'd0, addressed}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_tx_req"}, {31'd0, tx_req}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Stimulus
    initial begin
        bit         ack;
        logic [7:0] got;
        logic [7:0] a;
        logic [7:0] r;

        clks(5);
        check_reset_values("reset");
        reset = 1'b0;
        clks(3);
        allow_oe_glitch = 1'b0;

        // Directed write
        payload = {8'h55};
        xfer(8'h9A);

        // Address mismatch
        payload = {8'h12};
        xfer(8'h50);

        // Directed read: ACK first byte, NACK second
        payload = {8'hA5, 8'h3C};
        xfer(8'h9B);

        // Repeated START three bits into a write byte, then a read
        $display("[TB] xfer repeated-start after 3 bits");
        bus_start();
        write_byte(8'h9A, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd1);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        bus_start();
        check("rs_addressed_cleared", {31'd0, addressed}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd1);
        r = 8'($urandom);
        tx_src_q.push_back(r);
        write_byte(8'h9B, ack);
        check("rs_read_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(got, 1'b0);
        check("rs_read_byte", {24'd0, got}, {24'd0, r});
        bus_stop();
        clks(4);
        check("rs_busy_after_stop", {31'd0, busy}, 32'd0);
        check("rs_rx_pending", exp_rx_q.size(), 32'd0);

        // STOP four bits into a write byte
        $display("[TB] xfer stop after 4 bits");
        bus_start();
        write_byte(8'h9A, ack);
        check("ps_addr_ack", {31'd0, ack}, 32'd1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        write_bit(1'b0);
        bus_stop();
        clks(4);
        check("ps_busy", {31'd0, busy}, 32'd0);
        check("ps_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("ps_addressed", {31'd0, addressed}, 32'd0);
        check("ps_rx_data_unchanged", {24'd0, rx_data}, 32'h55);

        // Reset while the target drives the address ACK
        $display("[TB] xfer reset during ACK");
        bus_start();
        a = 8'h9A;
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        ctrl_sda_low = 1'b0;
        clks(Q);
        check("rst_ack_driven", {31'd0, sda_oe}, 32'd1);
        scl_in = 1'b1;
        clks(2);
        allow_oe_glitch = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        clks(3);
        allow_oe_glitch = 1'b0;

        // Randomised transactions
        for (int t = 0; t < 16; t++) begin
            int n;
            if ($urandom_range(0, 2) != 0) a = {ADDRESS, 1'($urandom_range(0, 1))};
            else a = 8'($urandom);
            n = $urandom_range(1, 4);
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            xfer(a);
        end

        check("oe_change_while_scl_high", oe_violations, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
